// File: rtl/esam_seq_ctrl.sv
// ESAM smart-card sequencer: power-up, warm reset and deactivation driven by CTRL/IRQ bus writes.
// A command in the wr_stb cycle changes state on the next edge; abort_in forces deactivation after a 2-flop sync.
module esam_seq_ctrl #(
   parameter int T_VCC = 2400,
   parameter int T_RST = 268800,
   parameter int T_OFF = 240
) (
   input  logic       fpga_clk,
   input  logic       sys_reset_n,
   input  logic       reg_cs,
   input  logic       reg_addr,
   input  logic       nwe,
   input  logic [7:0] wr_data,
   output logic [7:0] rd_data,
   input  logic       abort_in,
   output logic       esam_pwr_on,
   output logic       esam_clk_en,
   output logic       esam_io_en,
   output logic       esam_rst_n,
   output logic       busy,
   output logic       irq_out
);

   typedef enum logic [2:0] {
      S_OFF     = 3'd0,
      S_VCC_UP  = 3'd1,
      S_CLK_UP  = 3'd2,
      S_ACTIVE  = 3'd3,
      S_WARM    = 3'd4,
      S_DEA_RST = 3'd5,
      S_DEA_CLK = 3'd6
   } state_t;

   // Each timed state runs for its load value + 1 cycles, exiting on count 0.
   localparam logic [18:0] LD_VCC = 19'(T_VCC - 1);
   localparam logic [18:0] LD_RST = 19'(T_RST - 1);
   localparam logic [18:0] LD_OFF = 19'(T_OFF - 1);

   // {pwr, clk, io, rst_n, busy}
   function automatic logic [4:0] decode(input state_t s);
      case (s)
         S_OFF:     decode = 5'b0000_0;
         S_VCC_UP:  decode = 5'b1000_1;
         S_CLK_UP:  decode = 5'b1110_1;
         S_ACTIVE:  decode = 5'b1111_0;
         S_WARM:    decode = 5'b1110_1;
         S_DEA_RST: decode = 5'b1110_1;
         S_DEA_CLK: decode = 5'b1000_1;
         default:   decode = 5'b0000_0;
      endcase
   endfunction

   state_t      state;
   logic [18:0] cnt;
   logic [4:0]  out_q;
   logic        irq_pend;
   logic        irq_en;
   logic        abort_m;
   logic        abort_s;
   logic        we_q;
   logic        we_q2;
   logic        wr_stb;
   logic        wr_ctrl;
   logic        wr_irq;
   logic        act_cmd;
   logic        deact_cmd;
   logic        warm_cmd;
   logic        irq_clr;
   logic        cnt_zero;
   logic        unused_wr_bits;

   assign unused_wr_bits = ^wr_data[7:3];

   always_ff @(posedge fpga_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         abort_m <= 1'b0;
         abort_s <= 1'b0;
         we_q    <= 1'b0;
         we_q2   <= 1'b0;
      end else begin
         abort_m <= abort_in;
         abort_s <= abort_m;
         we_q    <= reg_cs & ~nwe;
         we_q2   <= we_q;
      end
   end

   // One pulse per bus write no matter how long nwe stays low.
   assign wr_stb  = we_q & ~we_q2;
   assign wr_ctrl = wr_stb & ~reg_addr;
   assign wr_irq  = wr_stb & reg_addr;

   // DEACT beats ACT beats WARM within a single write.
   assign deact_cmd = (wr_ctrl & wr_data[1]) | abort_s;
   assign act_cmd   = wr_ctrl & wr_data[0] & ~wr_data[1];
   assign warm_cmd  = wr_ctrl & wr_data[2] & ~wr_data[1] & ~wr_data[0];
   assign irq_clr   = wr_irq & wr_data[0];
   assign cnt_zero  = (cnt == 19'd0);

   always_ff @(posedge fpga_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         state    <= S_OFF;
         cnt      <= 19'd0;
         out_q    <= 5'b0;
         irq_pend <= 1'b0;
      end else begin
         // Clear first so any pend set later in this block wins.
         if (irq_clr) irq_pend <= 1'b0;
         if (!cnt_zero) cnt <= cnt - 19'd1;
         case (state)
            S_OFF: begin
               if (act_cmd && !abort_s) begin
                  state <= S_VCC_UP;
                  cnt   <= LD_VCC;
                  out_q <= decode(S_VCC_UP);
               end
            end
            S_VCC_UP: begin
               if (deact_cmd) begin
                  state <= S_DEA_CLK;
                  cnt   <= LD_OFF;
                  out_q <= decode(S_DEA_CLK);
               end else if (cnt_zero) begin
                  state <= S_CLK_UP;
                  cnt   <= LD_RST;
                  out_q <= decode(S_CLK_UP);
               end
            end
            S_CLK_UP, S_WARM: begin
               if (deact_cmd) begin
                  state <= S_DEA_RST;
                  cnt   <= LD_OFF;
                  out_q <= decode(S_DEA_RST);
               end else if (cnt_zero) begin
                  state    <= S_ACTIVE;
                  cnt      <= 19'd0;
                  out_q    <= decode(S_ACTIVE);
                  irq_pend <= 1'b1;
               end
            end
            S_ACTIVE: begin
               if (deact_cmd) begin
                  state <= S_DEA_RST;
                  cnt   <= LD_OFF;
                  out_q <= decode(S_DEA_RST);
               end else if (warm_cmd) begin
                  state <= S_WARM;
                  cnt   <= LD_RST;
                  out_q <= decode(S_WARM);
               end
            end
            S_DEA_RST: begin
               if (cnt_zero) begin
                  state <= S_DEA_CLK;
                  cnt   <= LD_OFF;
                  out_q <= decode(S_DEA_CLK);
               end
            end
            S_DEA_CLK: begin
               if (cnt_zero) begin
                  state    <= S_OFF;
                  cnt      <= 19'd0;
                  out_q    <= decode(S_OFF);
                  irq_pend <= 1'b1;
               end
            end
            default: begin
               state <= S_OFF;
               cnt   <= 19'd0;
               out_q <= decode(S_OFF);
            end
         endcase
      end
   end

   always_ff @(posedge fpga_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         irq_en <= 1'b0;
      end else if (wr_irq) begin
         irq_en <= wr_data[1];
      end
   end

   assign esam_pwr_on = out_q[4];
   assign esam_clk_en = out_q[3];
   assign esam_io_en  = out_q[2];
   assign esam_rst_n  = out_q[1];
   assign busy        = out_q[0];
   assign irq_out     = irq_pend & irq_en;

   always_comb begin
      rd_data = 8'h00;
      if (reg_cs) begin
         if (reg_addr)
            rd_data = {6'b0, irq_en, irq_pend};
         else
            rd_data = {2'b0, state, busy, (state == S_ACTIVE), abort_s};
      end
   end

endmodule

// File: tb/tb_esam_seq_ctrl.sv
// Directed bench for esam_seq_ctrl with short timing parameters (T_VCC=4, T_RST=8, T_OFF=2).
module tb_esam_seq_ctrl;

   logic       fpga_clk = 1'b0;
   logic       sys_reset_n;
   logic       reg_cs;
   logic       reg_addr;
   logic       nwe;
   logic [7:0] wr_data;
   logic [7:0] rd_data;
   logic       abort_in;
   logic       esam_pwr_on;
   logic       esam_clk_en;
   logic       esam_io_en;
   logic       esam_rst_n;
   logic       busy;
   logic       irq_out;

   int tests = 0;
   int fails = 0;

   esam_seq_ctrl #(.T_VCC(4), .T_RST(8), .T_OFF(2)) dut (
      .fpga_clk    (fpga_clk),
      .sys_reset_n (sys_reset_n),
      .reg_cs      (reg_cs),
      .reg_addr    (reg_addr),
      .nwe         (nwe),
      .wr_data     (wr_data),
      .rd_data     (rd_data),
      .abort_in    (abort_in),
      .esam_pwr_on (esam_pwr_on),
      .esam_clk_en (esam_clk_en),
      .esam_io_en  (esam_io_en),
      .esam_rst_n  (esam_rst_n),
      .busy        (busy),
      .irq_out     (irq_out)
   );

   always #5 fpga_clk = ~fpga_clk;

   // Status byte {2'b0, pwr, clk, io, rst_n, busy, irq_out}
   function automatic logic [7:0] st();
      return {2'b00, esam_pwr_on, esam_clk_en, esam_io_en, esam_rst_n, busy, irq_out};
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge fpga_clk);
   endtask

   // Strobe fires in the cycle after nwe falls; returns in the first cycle of the new state.
   task automatic wr(input logic a, input logic [7:0] d);
      reg_cs = 1'b1; reg_addr = a; wr_data = d; nwe = 1'b0;
      tick(1);
      reg_cs = 1'b0; nwe = 1'b1;
      tick(1);
   endtask

   task automatic chk_rd(input string tag, input logic a, input logic [7:0] exp);
      logic [7:0] v;
      reg_cs = 1'b1; reg_addr = a; nwe = 1'b1;
      #1;
      v = rd_data;
      reg_cs = 1'b0;
      chk(tag, v, exp);
   endtask

   localparam logic [7:0] ST_OFF   = 8'b00_0000_0_0;
   localparam logic [7:0] ST_OFFI  = 8'b00_0000_0_1;
   localparam logic [7:0] ST_VCC   = 8'b00_1000_1_0;
   localparam logic [7:0] ST_CLK   = 8'b00_1110_1_0;
   localparam logic [7:0] ST_ACT   = 8'b00_1111_0_0;
   localparam logic [7:0] ST_ACTI  = 8'b00_1111_0_1;

   initial begin
      sys_reset_n = 1'b0; reg_cs = 1'b0; reg_addr = 1'b0; nwe = 1'b1;
      wr_data = 8'h00; abort_in = 1'b0;
      tick(3);
      chk("reset_outputs", st(), ST_OFF);
      chk_rd("reset_ctrl", 1'b0, 8'h00);
      sys_reset_n = 1'b1;
      tick(2);
      chk_rd("post_reset_ctrl", 1'b0, 8'h00);
      chk_rd("post_reset_irq", 1'b1, 8'h00);

      wr(1'b1, 8'h02);
      chk_rd("irq_en_set", 1'b1, 8'h02);

      // Activation
      wr(1'b0, 8'h01);
      for (int i = 0; i < 4; i++) begin chk("act_vcc", st(), ST_VCC); tick(1); end
      for (int i = 0; i < 8; i++) begin chk("act_clk", st(), ST_CLK); tick(1); end
      chk("act_active", st(), ST_ACTI);
      chk_rd("act_ctrl", 1'b0, 8'h1A);
      chk_rd("act_irq", 1'b1, 8'h03);
      wr(1'b1, 8'h03);
      chk("irq_clear", st(), ST_ACT);

      // Warm reset, second WARM write inside WARM is ignored
      wr(1'b0, 8'h04);
      chk("warm_s0", st(), ST_CLK);
      wr(1'b0, 8'h04);
      chk("warm_s2", st(), ST_CLK);
      for (int i = 3; i <= 7; i++) begin tick(1); chk("warm_hold", st(), ST_CLK); end
      tick(1);
      chk("warm_done", st(), ST_ACTI);
      wr(1'b1, 8'h03);
      chk("warm_irq_clr", st(), ST_ACT);

      // 0x07 in ACTIVE: DEACT wins
      wr(1'b0, 8'h07);
      chk("dea_rst0", st(), ST_CLK);
      chk_rd("dea_rst_ctrl", 1'b0, 8'h2C);
      tick(1); chk("dea_rst1", st(), ST_CLK);
      tick(1); chk("dea_clk0", st(), ST_VCC);
      tick(1); chk("dea_clk1", st(), ST_VCC);
      tick(1); chk("dea_off", st(), ST_OFFI);
      wr(1'b1, 8'h03);
      chk("dea_irq_clr", st(), ST_OFF);

      // 0x03 in OFF: ignored
      wr(1'b0, 8'h03);
      chk("off_03", st(), ST_OFF);
      tick(5);
      chk_rd("off_03_ctrl", 1'b0, 8'h00);

      // Long nwe low with ACT: a single activation
      reg_cs = 1'b1; reg_addr = 1'b0; wr_data = 8'h01; nwe = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick(1);
         if (i == 5)  chk("long_act_vcc", st(), ST_VCC);
         if (i == 6)  chk("long_act_clk", st(), ST_CLK);
         if (i == 14) chk("long_act_active", st(), ST_ACTI);
      end
      chk("long_act_end", st(), ST_ACTI);
      reg_cs = 1'b0; nwe = 1'b1;
      tick(1);
      wr(1'b1, 8'h03);
      chk("long_act_irq_clr", st(), ST_ACT);

      // Long nwe low with WARM: WARM must not retrigger after returning to ACTIVE
      reg_cs = 1'b1; reg_addr = 1'b0; wr_data = 8'h04; nwe = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick(1);
         if (i == 2)  chk("long_warm_in", st(), ST_CLK);
         if (i == 9)  chk("long_warm_last", st(), ST_CLK);
         if (i == 10) chk("long_warm_out", st(), ST_ACTI);
      end
      chk("long_warm_end", st(), ST_ACTI);
      reg_cs = 1'b0; nwe = 1'b1;
      tick(1);
      wr(1'b1, 8'h03);

      // IRQ set beats a simultaneous W1C
      wr(1'b0, 8'h02);
      tick(4);
      chk("pre_race_off", st(), ST_OFFI);
      wr(1'b1, 8'h03);
      wr(1'b0, 8'h01);
      tick(10);
      wr(1'b1, 8'h03);
      chk("race_set_wins", st(), ST_ACTI);
      chk_rd("race_irq_reg", 1'b1, 8'h03);
      wr(1'b1, 8'h03);
      chk("later_clear", st(), ST_ACT);
      chk_rd("later_clear_reg", 1'b1, 8'h02);

      // Abort during CLK_UP
      wr(1'b0, 8'h02);
      tick(4);
      wr(1'b1, 8'h03);
      wr(1'b0, 8'h01);
      tick(5);
      chk("abort_pre", st(), ST_CLK);
      abort_in = 1'b1;
      tick(1); chk("abort_s6", st(), ST_CLK);
      tick(1); chk_rd("abort_synced", 1'b0, 8'h15);
      tick(1); chk_rd("abort_dea_rst", 1'b0, 8'h2D);
      chk("abort_rst0", st(), ST_CLK);
      tick(1); chk("abort_rst1", st(), ST_CLK);
      tick(1); chk("abort_clk0", st(), ST_VCC);
      tick(1); chk("abort_clk1", st(), ST_VCC);
      tick(1); chk("abort_off", st(), ST_OFFI);
      wr(1'b0, 8'h01);
      chk("abort_act_ign", st(), ST_OFFI);
      tick(3);
      chk_rd("abort_held_ctrl", 1'b0, 8'h01);
      abort_in = 1'b0;
      tick(3);
      chk_rd("abort_release_ctrl", 1'b0, 8'h00);
      wr(1'b1, 8'h03);

      // Reset during VCC_UP drops outputs without a clock edge
      wr(1'b0, 8'h01);
      tick(1);
      chk("rst_mid_vcc", st(), ST_VCC);
      #2 sys_reset_n = 1'b0;
      #1 chk("rst_mid_async", st(), ST_OFF);
      tick(2);
      sys_reset_n = 1'b1;
      tick(1);
      chk_rd("rst_mid_ctrl", 1'b0, 8'h00);
      chk_rd("rst_mid_irq", 1'b1, 8'h00);

      // DEACT in VCC_UP skips DEA_RST
      wr(1'b0, 8'h01);
      wr(1'b0, 8'h02);
      chk("vcc_deact", st(), ST_VCC);
      chk_rd("vcc_deact_ctrl", 1'b0, 8'h34);
      tick(1); chk("vcc_deact_clk1", st(), ST_VCC);
      tick(1); chk("vcc_deact_off", st(), ST_OFF);
      chk_rd("vcc_deact_pend", 1'b1, 8'h01);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/esam_seq_ctrl.md
ESAM_SEQ_CTRL -- requirements
Module: esam_seq_ctrl

Interface
REQ-001 Parameters (name, default, meaning): T_VCC, 2400, fpga_clk cycles from VCC on to clock on (100 us); T_RST, 268800, cycles RST held low with clock running (about 40000 ESAM clocks at 3.5712 MHz); T_OFF, 240, cycles per deactivation step (10 us).
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- fpga_clk, in, 1: 24 MHz clock.
- sys_reset_n, in, 1: asynchronous, active-low reset.
- reg_cs, in, 1: decoded MISC-bank select for this block.
- reg_addr, in, 1: register select; 0 = CTRL, 1 = IRQ.
- nwe, in, 1: bus write strobe, active low.
- wr_data, in, 8: bus write data.
- rd_data, out, 8: register read data.
- abort_in, in, 1: asynchronous forced-deactivate request, active high.
- esam_pwr_on, out, 1: ESAM VCC enable.
- esam_clk_en, out, 1: ESAM clock gate.
- esam_io_en, out, 1: ESAM data path enable.
- esam_rst_n, out, 1: ESAM RST line.
- busy, out, 1: sequence in progress.
- irq_out, out, 1: interrupt request.
REQ-003 Reset is sys_reset_n, asynchronous, active-low; the clock is fpga_clk.

Function
REQ-004 Write strobe: (reg_cs & !nwe) is registered, and wr_stb is a single-cycle pulse on its rising edge; a long nwe low SHALL produce exactly one wr_stb.
REQ-005 CTRL write bits: bit0 = ACT, bit1 = DEACT, bit2 = WARM; bits 7:3 are ignored. Priority when several bits are set in one write: DEACT > ACT > WARM.
REQ-006 abort_in SHALL pass through a 2-flop synchronizer (abort_s); abort_s high SHALL be treated as a DEACT command every cycle.
REQ-007 FSM states are OFF, VCC_UP, CLK_UP, ACTIVE, WARM, DEA_RST and DEA_CLK. A 19-bit down-counter is loaded on every state entry and the state exits when the counter equals 0.
REQ-008 Outputs are Moore-decoded from the state register, as {pwr, clk, io, rst_n}:
- OFF = 0000
- VCC_UP = 1000
- CLK_UP = 1110
- ACTIVE = 1111
- WARM = 1110
- DEA_RST = 1110
- DEA_CLK = 1000
REQ-009 OFF -> VCC_UP on ACT with abort_s low. VCC_UP lasts T_VCC cycles, then goes to CLK_UP.
REQ-010 CLK_UP lasts T_RST cycles, then goes to ACTIVE.
REQ-011 ACTIVE -> WARM on WARM. WARM lasts T_RST cycles, then returns to ACTIVE.
REQ-012 DEACT or abort_s in VCC_UP, CLK_UP, ACTIVE or WARM SHALL enter DEA_RST on the next edge, aborting the running count.
REQ-013 DEACT or abort_s in VCC_UP SHALL go to DEA_CLK instead, because the clock is not yet running.
REQ-014 DEA_RST lasts T_OFF cycles, then goes to DEA_CLK. DEA_CLK lasts T_OFF cycles, then goes to OFF.
REQ-015 Ignored commands (no state change):
- ACT outside OFF.
- WARM outside ACTIVE.
- Any command in DEA_RST or DEA_CLK.
- DEACT in OFF.
REQ-016 busy SHALL be 1 in VCC_UP, CLK_UP, WARM, DEA_RST and DEA_CLK, and 0 in OFF and ACTIVE.
REQ-017 irq_pend SHALL set on entry to ACTIVE from CLK_UP or WARM, and on entry to OFF from DEA_CLK.
REQ-018 An IRQ write with bit0 = 1 SHALL clear irq_pend (W1C). A simultaneous set SHALL win over the clear.
REQ-019 IRQ register bit1 = irq_en (read/write). irq_out = irq_pend & irq_en.
REQ-020 rd_data is combinational and equals 0 when reg_cs = 0.
- CTRL reads {2'b0, state[2:0], busy, active, abort_s}, where active = (state == ACTIVE).
- IRQ reads {6'b0, irq_en, irq_pend}.
- State encoding: OFF = 0, VCC_UP = 1, CLK_UP = 2, ACTIVE = 3, WARM = 4, DEA_RST = 5, DEA_CLK = 6.
REQ-021 Command latency: a command carried by wr_stb in cycle N SHALL change state at the edge ending cycle N. Outputs SHALL reflect the new state from cycle N+1.

Reset
REQ-022 On sys_reset_n low:
- state = OFF, counter = 0, irq_pend = 0, irq_en = 0.
- All ESAM outputs are 0, busy = 0, irq_out = 0.
- Synchronizer and strobe flops are 0.
REQ-023 Reset asserted mid-sequence SHALL drop esam_pwr_on, esam_clk_en, esam_io_en and esam_rst_n immediately (asynchronously), without running the deactivation steps.

Verification (T_VCC = 4, T_RST = 8, T_OFF = 2)
REQ-024 Activation:
- Stimulus: write CTRL = 0x01 from OFF.
- Response: pwr = 1 for 4 cycles, then clk = io = 1 with rst_n = 0 for 8 cycles, then rst_n = 1.
- irq_pend = 1 and busy = 0 at ACTIVE.
REQ-025 Warm reset:
- Stimulus: in ACTIVE, write CTRL = 0x04.
- Response: rst_n = 0 for 8 cycles while pwr, clk and io stay 1, then rst_n = 1.
- A second CTRL = 0x04 written during WARM is ignored.
REQ-026 Abort mid-activation:
- Stimulus: abort_in high during CLK_UP.
- Response: within 3 cycles, rst_n = 0 in DEA_RST for 2 cycles, then DEA_CLK (clk = io = 0) for 2 cycles, then OFF with pwr = 0 and irq_pend = 1.
- An ACT write while abort_in stays high is ignored.
REQ-027 Simultaneous commands:
- Stimulus: write CTRL = 0x03 in OFF.
- Response: no state change, since DEACT wins and is ignored in OFF.
- Stimulus: write CTRL = 0x07 in ACTIVE.
- Response: enters DEA_RST.
REQ-028 Strobe and IRQ:
- Hold nwe low for 20 cycles with CTRL = 0x01: exactly one activation occurs.
- With irq_en = 1, write IRQ = 0x03 in the cycle the pend sets: irq_out stays 1.
- Write IRQ = 0x03 in a later cycle: irq_out clears.
REQ-029 Reset mid-sequence:
- Stimulus: assert sys_reset_n low during VCC_UP.
- Response: all outputs are 0 asynchronously.
- After reset release, rd_data for CTRL = 0x00.
